// File: rtl/alub_operand_stage.sv
// Registered ALU B operand stage: selects/extends the B operand and builds wide literals
// from a byte-wise prefix accumulator, behind a single valid/ready pipeline register.
module alub_operand_stage #(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] ALUB_DIN,
  input  logic [2:0]        ALUB_SRCX,
  input  logic [3:0]        ARGA_X,
  input  logic [3:0]        ARGB_X,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] ALUB_DATA,
  output logic              PFX_PENDING,
  output logic              PFX_OVF
);

  localparam int PFX_BYTES = DATA_W / 8 - 1;
  localparam int PFX_W     = PFX_BYTES * 8;
  localparam int CNT_W     = $clog2(PFX_BYTES + 1);

  typedef enum logic [2:0] {
    MODE_REG_B = 3'd0,
    MODE_U8H   = 3'd1,
    MODE_U8    = 3'd2,
    MODE_S8    = 3'd3,
    MODE_U4    = 3'd4,
    MODE_U4_0  = 3'd5,
    MODE_PFX   = 3'd6,
    MODE_U8P   = 3'd7
  } mode_e;

  logic              out_valid_reg;
  logic [DATA_W-1:0] alub_data_reg;
  logic [PFX_W-1:0]  pfx_reg;
  logic [CNT_W-1:0]  pfx_cnt_reg;
  logic              pfx_ovf_reg;

  mode_e             mode;
  logic [7:0]        arg_byte;
  logic              accept;
  logic              is_pfx;
  logic              pfx_full;
  logic [PFX_W-1:0]  pfx_next;
  logic [DATA_W-1:0] operand_next;

  assign mode     = mode_e'(ALUB_SRCX);
  assign arg_byte = {ARGA_X, ARGB_X};
  assign IN_READY = !out_valid_reg || OUT_READY;
  assign accept   = IN_VALID && IN_READY;
  assign is_pfx   = (mode == MODE_PFX);
  assign pfx_full = (pfx_cnt_reg == CNT_W'(PFX_BYTES));

  // Shifting left by a byte naturally discards the oldest byte once the register is full.
  assign pfx_next = (pfx_reg << 8) | PFX_W'(arg_byte);

  always_comb begin
    operand_next = '0;
    case (mode)
      MODE_REG_B: operand_next = ALUB_DIN;
      MODE_U8H:   operand_next = {arg_byte, ALUB_DIN[DATA_W-9:0]};
      MODE_U8:    operand_next = DATA_W'(arg_byte);
      MODE_S8:    operand_next = {{(DATA_W-8){ARGA_X[3]}}, arg_byte};
      MODE_U4:    operand_next = DATA_W'(ARGB_X);
      MODE_U4_0:  operand_next = DATA_W'({ARGB_X, 1'b0});
      MODE_U8P:   operand_next = {pfx_reg, arg_byte};
      default:    operand_next = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid_reg <= 1'b0;
      alub_data_reg <= '0;
      pfx_reg       <= '0;
      pfx_cnt_reg   <= '0;
      pfx_ovf_reg   <= 1'b0;
    end else begin
      // A PFX accept produces no operand, so a consumed output simply empties.
      if (accept && !is_pfx) begin
        alub_data_reg <= operand_next;
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && OUT_READY) begin
        out_valid_reg <= 1'b0;
      end

      if (accept) begin
        if (is_pfx) begin
          pfx_reg <= pfx_next;
          if (pfx_full) begin
            pfx_ovf_reg <= 1'b1;
          end else begin
            pfx_cnt_reg <= pfx_cnt_reg + CNT_W'(1);
          end
        end else begin
          pfx_reg     <= '0;
          pfx_cnt_reg <= '0;
          pfx_ovf_reg <= 1'b0;
        end
      end
    end
  end

  assign OUT_VALID   = out_valid_reg;
  assign ALUB_DATA   = alub_data_reg;
  assign PFX_PENDING = (pfx_cnt_reg != '0);
  assign PFX_OVF     = pfx_ovf_reg;

endmodule

// File: doc/alub_operand_stage.md
# alub_operand_stage

Parametrised, registered successor to the combinational ALU B input mux. Selects and extends the ALU B operand from the register-file B port or the instruction argument nibbles, and adds a multi-byte immediate prefix accumulator so that full-width literals can be built from byte-sized argument fields. Sits between decode/register read and the ALU B input. Provides one pipeline stage with a valid/ready handshake.

## Interface
- DATA_W, 16: operand width; multiple of 8, at least 16.
- PFX_BYTES (localparam), DATA_W/8-1: prefix accumulator capacity in bytes.

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset, synchronous and active-high.
- IN_VALID  in  1  request present.
- IN_READY  out  1  stage can accept a request.
- ALUB_DIN  in  DATA_W  register B value.
- ALUB_SRCX  in  3  operand mode, listed under Operation.
- ARGA_X  in  4  argument high nibble.
- ARGB_X  in  4  argument low nibble.
- OUT_VALID  out  1  ALUB_DATA holds a valid operand.
- OUT_READY  in  1  ALU consumes the operand.
- ALUB_DATA  out  DATA_W  registered operand.
- PFX_PENDING  out  1  prefix accumulator holds at least one byte.
- PFX_OVF  out  1  sticky flag: more than PFX_BYTES prefix bytes were pushed.

## Operation
- BYTE = {ARGA_X, ARGB_X}. Accept = IN_VALID && IN_READY.
- Mode 0, REG_B: ALUB_DIN.
- Mode 1, U8H: ALUB_DIN with bits [DATA_W-1:DATA_W-8] replaced by BYTE.
- Mode 2, U8: zero-extended BYTE.
- Mode 3, S8: BYTE sign-extended from ARGA_X[3].
- Mode 4, U4: zero-extended ARGB_X.
- Mode 5, U4_0: zero-extended {ARGB_X, 1'b0}.
- Mode 6, PFX: pushes BYTE into the prefix register: PFX_REG <= (PFX_REG << 8) | BYTE, truncated to PFX_BYTES*8 bits.
  - PFX_CNT increments and saturates at PFX_BYTES.
  - A push with PFX_CNT == PFX_BYTES drops the oldest byte and sets PFX_OVF.
  - No output is produced. OUT_VALID and ALUB_DATA are unaffected by the push itself.
- Mode 7, U8P: output = {PFX_REG, BYTE}, zero-extended to DATA_W.
  - Clears PFX_REG, PFX_CNT and PFX_OVF.
  - With PFX_CNT == 0 the result equals U8.
- Any accepted mode 0–5 also clears PFX_REG, PFX_CNT and PFX_OVF, so an unused prefix is discarded.
- PFX_PENDING = (PFX_CNT != 0).

## Timing
- Reset values: OUT_VALID 0, ALUB_DATA 0, PFX_REG 0, PFX_CNT 0, PFX_OVF 0, PFX_PENDING 0. IN_READY is 1 in the first cycle after reset.
- IN_READY = !OUT_VALID || OUT_READY (combinational). This applies to every mode, including PFX.
- Latency: an accepted mode 0–5 or 7 request appears on ALUB_DATA with OUT_VALID=1 in the next cycle.
- Throughput: one operand per cycle while OUT_READY=1.
- Output register update:
  - Accept of a non-PFX mode loads ALUB_DATA and sets OUT_VALID.
  - OUT_VALID && OUT_READY with no non-PFX accept clears OUT_VALID. ALUB_DATA keeps its last value.
  - Accept of a PFX in the same cycle that the output is consumed clears OUT_VALID.
- Backpressure: while OUT_VALID && !OUT_READY, ALUB_DATA and OUT_VALID hold, and IN_READY=0.
- Inputs are sampled only on accept. Changes to inputs while IN_READY=0 have no effect.
- RESET has priority over everything, including mid-prefix sequences and held outputs. The next accept after reset sees an empty prefix.
- All arithmetic is unsigned concatenation or shift. There is no carry. Overflow is reported only through PFX_OVF.

## Test plan
- S8/U8H: S8 with A=8, B=0 -> ALUB_DATA=0xFF80, OUT_VALID=1 one cycle later. Then U8H with DIN=0x1234, A=0xA, B=0xB -> 0xAB34.
- Prefix build (DATA_W=16): PFX with BYTE=0x12 -> PFX_PENDING=1, OUT_VALID stays 0. Then U8P with BYTE=0x34 -> 0x1234, PFX_PENDING=0.
- Overflow (DATA_W=16): PFX 0x12, then PFX 0x56 (PFX_OVF=1), then U8P 0x78 -> 0x5678, and PFX_OVF returns to 0. With DATA_W=32: PFX 0x12, PFX 0x34, PFX 0x56, then U8P 0x78 -> 0x12345678, with PFX_OVF=0 throughout.
- Discard: PFX 0x12, then U4 with B=0x5 -> 0x0005, PFX_PENDING=0. Then U8P 0x34 -> 0x0034.
- Backpressure: hold OUT_READY=0 with an output valid and IN_VALID=1 carrying changing inputs -> IN_READY=0, ALUB_DATA stable for 5 cycles. Raise OUT_READY -> the pending request is loaded next cycle, and no request is lost or duplicated.
- Reset mid-operation: PFX 0x12, assert RESET for 1 cycle with OUT_VALID=1 -> all outputs return to reset values. Then U8P 0x34 -> 0x0034.
